// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store unit: turns pipeline memory ops into req/ack bus transactions.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state timeout that aborts with err.
`timescale 1ns/1ps

module lsu_mem_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic          reg_wr,
    input  logic [1:0]    wb_sel,
    input  logic [4:0]    rd,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          wb_valid,
    output logic          wb_reg_wr,
    output logic [1:0]    wb_sel_o,
    output logic [4:0]    wb_rd,
    output logic [DW-1:0] load_data,
    output logic          misalign,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic          regWr_q, regWr_d;
    logic [1:0]    wbSel_q, wbSel_d;
    logic [4:0]    rd_q, rd_d;
    logic          wbValid_q, wbValid_d;
    logic          wbRegWr_q, wbRegWr_d;
    logic [DW-1:0] loadData_q, loadData_d;
    logic          misalign_q, misalign_d;
`ifdef MEM_TIMEOUT_EN
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;
`endif

    logic          access;
    logic          aligned;
    logic [3:0]    beNew;
    logic [DW-1:0] wdataNew;
    logic [DW-1:0] shifted;
    logic [DW-1:0] loadVal;

    // Request decode: alignment, byte lanes and lane-replicated store data.
    // Size 11 is handled as a word everywhere.
    always_comb begin
        access   = rd_en | wr_en;
        aligned  = 1'b1;
        beNew    = 4'b1111;
        wdataNew = wdata;
        case (funct3[1:0])
            2'b00: begin
                beNew    = 4'b0001 << addr[1:0];
                wdataNew = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned  = ~addr[0];
                beNew    = 4'b0011 << {addr[1], 1'b0};
                wdataNew = {2{wdata[15:0]}};
            end
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Load extraction uses the size and byte offset captured at request time.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   loadVal = funct3_q[2] ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   loadVal = funct3_q[2] ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: loadVal = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        regWr_d    = regWr_q;
        wbSel_d    = wbSel_q;
        rd_d       = rd_q;
        loadData_d = loadData_q;
        wbValid_d  = 1'b0;
        wbRegWr_d  = 1'b0;
        misalign_d = 1'b0;
        stall      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err_d      = 1'b0;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (access && aligned) begin
                    stall    = 1'b1;
                    req_d    = 1'b1;
                    we_d     = wr_en;
                    addr_d   = {addr[AW-1:2], 2'b00};
                    wdata_d  = wdataNew;
                    be_d     = beNew;
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    regWr_d  = reg_wr;
                    wbSel_d  = wb_sel;
                    rd_d     = rd;
                    state_d  = S_WAIT;
`ifdef MEM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else if (access) begin
                    misalign_d = 1'b1;
                    wbValid_d  = 1'b1;
                    wbSel_d    = wb_sel;
                    rd_d       = rd;
                    loadData_d = '0;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                // An ack always beats a simultaneous timeout.
                if (mem_ack) begin
                    req_d      = 1'b0;
                    loadData_d = we_q ? '0 : loadVal;
                    wbValid_d  = 1'b1;
                    wbRegWr_d  = regWr_q;
                    state_d    = S_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    req_d      = 1'b0;
                    loadData_d = '0;
                    wbValid_d  = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_RESP;
                end
`endif
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            regWr_q    <= 1'b0;
            wbSel_q    <= '0;
            rd_q       <= '0;
            wbValid_q  <= 1'b0;
            wbRegWr_q  <= 1'b0;
            loadData_q <= '0;
            misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q      <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            regWr_q    <= regWr_d;
            wbSel_q    <= wbSel_d;
            rd_q       <= rd_d;
            wbValid_q  <= wbValid_d;
            wbRegWr_q  <= wbRegWr_d;
            loadData_q <= loadData_d;
            misalign_q <= misalign_d;
`ifdef MEM_TIMEOUT_EN
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign wb_valid  = wbValid_q;
    assign wb_reg_wr = wbRegWr_q;
    assign wb_sel_o  = wbSel_q;
    assign wb_rd     = rd_q;
    assign load_data = loadData_q;
    assign misalign  = misalign_q;
`ifdef MEM_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized accesses
// compared against a byte-lane reference model.
`timescale 1ns/1ps

module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en, wr_en, reg_wr;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, wb_valid, wb_reg_wr;
    logic [1:0]  wb_sel_o;
    logic [4:0]  wb_rd;
    logic [31:0] load_data;
    logic        misalign, err;

    int tests = 0;
    int fails = 0;

    // Observations gathered over one transaction window.
    int          oStall, oReq, oWb, oMis, oErr;
    logic        oUnstable;
    logic [31:0] oAddr, oWdata, oLoad;
    logic [3:0]  oBe;
    logic        oWe, oRegWr;
    logic [4:0]  oRd;
    logic [1:0]  oSel;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .reg_wr(reg_wr),
        .wb_sel(wb_sel), .rd(rd), .funct3(funct3), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_sel_o(wb_sel_o), .wb_rd(wb_rd),
        .load_data(load_data), .misalign(misalign), .err(err)
    );

    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int n,
                                             input logic uns, input int off);
        longint v;
        longint full;
        full = longint'(1) << (8 * n);
        v = rdata;
        v = (v >> (8 * off)) % full;
        if (!uns && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    // Presents one access in an IDLE cycle, acks it in WAIT cycle ackDelay
    // (0 = never), pokes a spurious ack alongside wb_valid, and records what it saw.
    task automatic run_access(input logic rdv, input logic wrv, input logic regwr,
                              input logic [1:0] sel, input logic [4:0] rdd,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int ackDelay,
                              input logic [31:0] rdata, input int window);
        @(negedge clk);
        rd_en = rdv; wr_en = wrv; reg_wr = regwr; wb_sel = sel; rd = rdd;
        funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
        #1;
        oStall = stall ? 1 : 0;
        oReq = 0; oWb = 0; oMis = 0; oErr = 0; oUnstable = 1'b0;
        oLoad = 'x; oRegWr = 1'bx; oRd = 'x; oSel = 'x;
        for (int c = 0; c < window; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                rd_en = 1'b0; wr_en = 1'b0;
                oAddr = mem_addr; oBe = mem_be; oWdata = mem_wdata; oWe = mem_we;
            end
            if (mem_req === 1'b1) begin
                oReq++;
                if (mem_addr !== oAddr || mem_be !== oBe || mem_wdata !== oWdata || mem_we !== oWe)
                    oUnstable = 1'b1;
            end
            if (stall === 1'b1) oStall++;
            if (misalign === 1'b1) oMis++;
            if (err === 1'b1) oErr++;
            if (wb_valid === 1'b1) begin
                oWb++;
                oLoad = load_data; oRegWr = wb_reg_wr; oRd = wb_rd; oSel = wb_sel_o;
            end
            if (ackDelay != 0 && mem_req === 1'b1 && oReq == ackDelay) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end else if (wb_valid === 1'b1) begin
                mem_ack = 1'b1; mem_rdata = $urandom;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_en = 0; wr_en = 0; reg_wr = 0; wb_sel = 0; rd = 0;
        funct3 = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall} !== '0) begin
            fails++; $display("[TB] FAIL reset_bus got %b %b %h %h %b %b want all 0",
                              mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall);
        end
        tests++;
        if ({wb_valid, wb_reg_wr, wb_sel_o, wb_rd, load_data, misalign, err} !== '0) begin
            fails++; $display("[TB] FAIL reset_wb got %b %b %h %h %h %b %b want all 0",
                              wb_valid, wb_reg_wr, wb_sel_o, wb_rd, load_data, misalign, err);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word_load();
        run_access(1, 0, 1, 2'd1, 5'd7, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 5);
        tests++; if (oBe !== 4'b1111) begin fails++; $display("[TB] FAIL word_be got %b want 1111", oBe); end
        tests++; if (oStall != 4) begin fails++; $display("[TB] FAIL word_stall got %0d want 4", oStall); end
        tests++; if (oWb != 1) begin fails++; $display("[TB] FAIL word_wbvalid got %0d want 1", oWb); end
        tests++; if (oLoad !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL word_load got %h want deadbeef", oLoad); end
        tests++; if (oRegWr !== 1'b1 || oRd !== 5'd7 || oSel !== 2'd1) begin
            fails++; $display("[TB] FAIL word_wbctl got %b %0d %0d want 1 7 1", oRegWr, oRd, oSel);
        end
        tests++; if (oAddr !== 32'h100 || oReq != 3) begin
            fails++; $display("[TB] FAIL word_req got addr %h cycles %0d want 100 3", oAddr, oReq);
        end
    endtask

    task automatic test_byte_load();
        run_access(1, 0, 1, 2'd1, 5'd3, 3'b000, 32'h203, 32'h0, 1, 32'h80112233, 3);
        tests++; if (oLoad !== 32'hFFFFFF80) begin fails++; $display("[TB] FAIL lb_signed got %h want ffffff80", oLoad); end
        tests++; if (oBe !== 4'b1000 || oAddr !== 32'h200) begin
            fails++; $display("[TB] FAIL lb_lane got be %b addr %h want 1000 200", oBe, oAddr);
        end
        tests++; if (oStall != 2) begin fails++; $display("[TB] FAIL lb_min_latency got %0d want 2", oStall); end
        run_access(1, 0, 1, 2'd1, 5'd3, 3'b100, 32'h203, 32'h0, 2, 32'h80112233, 4);
        tests++; if (oLoad !== 32'h00000080) begin fails++; $display("[TB] FAIL lbu got %h want 00000080", oLoad); end
    endtask

    task automatic test_half_store();
        run_access(0, 1, 0, 2'd0, 5'd0, 3'b001, 32'h42, 32'h0000ABCD, 2, 32'h12345678, 4);
        tests++; if (oWe !== 1'b1 || oAddr !== 32'h40) begin
            fails++; $display("[TB] FAIL sh_cmd got we %b addr %h want 1 40", oWe, oAddr);
        end
        tests++; if (oBe !== 4'b1100) begin fails++; $display("[TB] FAIL sh_be got %b want 1100", oBe); end
        tests++; if (oWdata !== 32'hABCDABCD) begin fails++; $display("[TB] FAIL sh_wdata got %h want abcdabcd", oWdata); end
        tests++; if (oLoad !== 32'h0 || oUnstable) begin
            fails++; $display("[TB] FAIL sh_load got %h unstable %b want 0 0", oLoad, oUnstable);
        end
    endtask

    task automatic test_misalign();
        run_access(1, 0, 1, 2'd2, 5'd9, 3'b010, 32'h101, 32'h0, 1, 32'hFFFFFFFF, 3);
        tests++; if (oReq != 0 || oStall != 0) begin
            fails++; $display("[TB] FAIL mis_bus got req %0d stall %0d want 0 0", oReq, oStall);
        end
        tests++; if (oMis != 1 || oWb != 1) begin
            fails++; $display("[TB] FAIL mis_pulse got mis %0d wb %0d want 1 1", oMis, oWb);
        end
        tests++; if (oRegWr !== 1'b0) begin fails++; $display("[TB] FAIL mis_regwr got %b want 0", oRegWr); end
    endtask

    task automatic test_back_to_back();
        run_access(1, 1, 1, 2'd1, 5'd4, 3'b010, 32'h80, 32'hCAFEF00D, 1, 32'h55555555, 3);
        tests++; if (oWe !== 1'b1 || oWdata !== 32'hCAFEF00D || oLoad !== 32'h0) begin
            fails++; $display("[TB] FAIL b2b_store got we %b wdata %h load %h want 1 cafef00d 0", oWe, oWdata, oLoad);
        end
        run_access(1, 0, 1, 2'd1, 5'd5, 3'b101, 32'h82, 32'h0, 1, 32'h9ABC1234, 3);
        tests++; if (oLoad !== 32'h00009ABC || oStall != 2 || oWb != 1) begin
            fails++; $display("[TB] FAIL b2b_load got %h stall %0d wb %0d want 00009abc 2 1", oLoad, oStall, oWb);
        end
    endtask

    task automatic test_ack_in_idle();
        int wbSeen = 0;
        int reqSeen = 0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        repeat (3) begin
            @(posedge clk); #1;
            if (wb_valid === 1'b1) wbSeen++;
            if (mem_req === 1'b1 || stall === 1'b1) reqSeen++;
        end
        mem_ack = 1'b0;
        tests++; if (wbSeen != 0 || reqSeen != 0) begin
            fails++; $display("[TB] FAIL idle_ack got wb %0d req %0d want 0 0", wbSeen, reqSeen);
        end
    endtask

    task automatic test_reset_mid_wait();
        int wbSeen = 0;
        @(negedge clk);
        rd_en = 1; wr_en = 0; reg_wr = 1; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        rd_en = 0;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("[TB] FAIL rst_wait_req got %b want 1", mem_req); end
        #1 reset = 1'b1;
        #1;
        tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("[TB] FAIL rst_async got req %b stall %b want 0 0", mem_req, stall);
        end
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        repeat (3) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (wb_valid === 1'b1 || mem_req === 1'b1) wbSeen++;
        end
        tests++; if (wbSeen != 0) begin fails++; $display("[TB] FAIL rst_ack_discard got %0d want 0", wbSeen); end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        run_access(1, 0, 1, 2'd1, 5'd6, 3'b010, 32'h300, 32'h0, 0, 32'h0, 20);
        tests++; if (oReq != 16 || oStall != 17) begin
            fails++; $display("[TB] FAIL tmo_req got req %0d stall %0d want 16 17", oReq, oStall);
        end
        tests++; if (oErr != 1 || oWb != 1 || oRegWr !== 1'b0 || oLoad !== 32'h0) begin
            fails++; $display("[TB] FAIL tmo_abort got err %0d wb %0d regwr %b load %h want 1 1 0 0",
                              oErr, oWb, oRegWr, oLoad);
        end
`else
        run_access(1, 0, 1, 2'd1, 5'd6, 3'b010, 32'h300, 32'h0, 20, 32'h13579BDF, 22);
        tests++; if (oReq != 20 || oWb != 1 || oErr != 0 || oLoad !== 32'h13579BDF) begin
            fails++; $display("[TB] FAIL long_wait got req %0d wb %0d err %0d load %h want 20 1 0 13579bdf",
                              oReq, oWb, oErr, oLoad);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic rdv, wrv, regwr, ok, uns;
            logic [1:0] sel;
            logic [4:0] rdd;
            logic [2:0] f3;
            logic [31:0] a, wd, rdata, expWd, expLoad;
            logic [3:0] expBe;
            int n, off, dly;
            rdv = 1'($urandom); wrv = 1'($urandom); regwr = 1'($urandom);
            if (!rdv && !wrv) rdv = 1'b1;
            sel = 2'($urandom); rdd = 5'($urandom); f3 = 3'($urandom);
            a = $urandom; wd = $urandom; rdata = $urandom;
            dly = $urandom_range(1, 6);
            n = size_bytes(f3); off = int'(a[1:0]); uns = f3[2];
            ok = (off % n) == 0;
            for (int b = 0; b < 4; b++) begin
                expBe[b] = (b >= off) && (b < off + n);
                expWd[8*b +: 8] = wd[8*(b % n) +: 8];
            end
            expLoad = (ok && !wrv) ? ref_load(rdata, n, uns, off) : 32'h0;
            run_access(rdv, wrv, regwr, sel, rdd, f3, a, wd, dly, rdata, dly + 2);
            tests++; if (oStall != (ok ? dly + 1 : 0) || oReq != (ok ? dly : 0)) begin
                fails++; $display("[TB] FAIL rnd%0d_timing got stall %0d req %0d want %0d %0d",
                                  i, oStall, oReq, ok ? dly + 1 : 0, ok ? dly : 0);
            end
            tests++; if (oWb != 1 || oMis != (ok ? 0 : 1) || oErr != 0) begin
                fails++; $display("[TB] FAIL rnd%0d_pulses got wb %0d mis %0d err %0d want 1 %0d 0",
                                  i, oWb, oMis, oErr, ok ? 0 : 1);
            end
            tests++; if (oLoad !== expLoad || oRegWr !== (ok ? regwr : 1'b0) || oRd !== rdd || oSel !== sel) begin
                fails++; $display("[TB] FAIL rnd%0d_wb got %h %b %0d %0d want %h %b %0d %0d",
                                  i, oLoad, oRegWr, oRd, oSel, expLoad, ok ? regwr : 1'b0, rdd, sel);
            end
            if (ok) begin
                tests++;
                if (oAddr !== {a[31:2], 2'b00} || oBe !== expBe || oWe !== wrv || oUnstable ||
                    (wrv && oWdata !== expWd)) begin
                    fails++; $display("[TB] FAIL rnd%0d_bus got %h %b %b %h unstable %b want %h %b %b %h",
                                      i, oAddr, oBe, oWe, oWdata, oUnstable, {a[31:2], 2'b00}, expBe, wrv, expWd);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misalign();
        test_back_to_back();
        test_ack_in_idle();
        test_reset_mid_wait();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store unit: the consumer of the registered rd_en/wr_en/reg_wr/wb_sel control from the execute/memory pipeline register.
- Turns each memory instruction into a req/ack transaction on the data-memory bus and stalls the pipeline while the transaction is outstanding.
- Returns aligned, sign- or zero-extended load data plus writeback control to the writeback stage.

Parameters:
- DW, 32, data width (fixed at 32 for this core; byte lanes = DW/8).
- AW, 32, address width.
- TIMEOUT, 16, WAIT-state cycles before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_en  in  1  load request from pipeline register
- wr_en  in  1  store request from pipeline register
- reg_wr  in  1  register-write enable of current instruction
- wb_sel  in  2  writeback select of current instruction
- rd  in  5  destination register
- funct3  in  3  size: [1:0] 00 byte, 01 half, 10 word; [2] unsigned load
- addr  in  AW  byte address
- wdata  in  DW  store data, right-justified
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_wdata  out  DW  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  DW  read data, valid with mem_ack
- stall  out  1  freeze upstream pipeline
- wb_valid  out  1  one-cycle completion pulse
- wb_reg_wr  out  1  registered reg_wr (forced 0 on fault)
- wb_sel_o  out  2  registered wb_sel
- wb_rd  out  5  registered rd
- load_data  out  DW  extended load result
- misalign  out  1  one-cycle misaligned-access pulse
- err  out  1  one-cycle timeout pulse (0 without feature)

Behaviour:
- Reset: state IDLE; every output 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall, wb_*, load_data, misalign, err). Reset mid-transaction drops mem_req asynchronously; a pending ack is discarded.
- Access = rd_en | wr_en. If both are set, treat as a store (wr_en wins).
- Alignment: word requires addr[1:0]=00; half requires addr[0]=0; funct3[1:0]=11 is treated as word.
- IDLE, aligned access:
  - stall=1 combinationally in the same cycle.
  - Latch addr, be, replicated wdata, we, funct3, addr[1:0], reg_wr, wb_sel and rd.
  - Next state WAIT; mem_req=1 from the next cycle.
- IDLE, misaligned access:
  - No bus request, no stall.
  - Next cycle: misalign=1 and wb_valid=1 with wb_reg_wr=0.
- WAIT:
  - stall=1; mem_req=1; all mem_* outputs held stable.
  - On mem_ack: mem_req=0 next cycle; load_data registered from mem_rdata (0 for stores); state RESP.
  - Ack latency 0 is not possible: earliest ack is in the first WAIT cycle, so minimum load latency is 2 stall cycles.
- RESP:
  - wb_valid=1 for exactly one cycle; stall=0, so the pipeline advances.
  - Next state IDLE. A new access is sampled only in IDLE (the following cycle).
- mem_ack in IDLE or RESP is ignored.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],1'b0}; word = 1111.
- Store data replication: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}.
- Load extraction: shift mem_rdata right by addr[1:0]*8, take 8/16/32 bits, sign-extend if funct3[2]=0, else zero-extend.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT-1 with no ack: mem_req drops next cycle, state RESP, err=1 for the RESP cycle, wb_reg_wr=0, load_data=0.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Test Plan:
- Word load addr=0x100, ack after 3 WAIT cycles, rdata=0xDEADBEEF -> mem_be=1111, stall high 4 cycles, wb_valid pulse, load_data=0xDEADBEEF, wb_reg_wr=1.
- Signed byte load addr=0x203, rdata=0x80112233 -> load_data=0xFFFFFF80; same access with funct3=100 -> 0x00000080.
- Half store addr=0x42, wdata=0x0000ABCD -> mem_we=1, mem_addr=0x40, mem_be=1100, mem_wdata=0xABCDABCD, load_data=0.
- Word load addr=0x101 -> no mem_req, stall=0, misalign and wb_valid pulse once, wb_reg_wr=0.
- Reset asserted while in WAIT with mem_req=1 -> mem_req=0 immediately; ack the next cycle produces no wb_valid.
- (MEM_TIMEOUT_EN, TIMEOUT=16) load with no ack -> mem_req high 16 cycles, then err=1 and wb_valid=1, wb_reg_wr=0, load_data=0.
